// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl
//   Unified instruction/data word memory for the multicycle core, with a
//   latency-controlled request/ready handshake and address-error reporting.
//   One transaction is in flight at a time; requests are accepted only in IDLE.
//
// Ports
//   clk        in   clock, all state updates on rising edge
//   Reset      in   synchronous active-low reset (0 = reset)
//   MemReq     in   request strobe, sampled only in IDLE
//   Adr        in   32-bit byte address
//   WriteData  in   32-bit store data
//   MemWrite   in   1 = write, 0 = read
//   ReadData   out  registered read result, held until the next valid read
//   MemReady   out  one-cycle completion pulse (RESP state)
//   AdrErr     out  qualifies MemReady: 1 = access rejected
//   Busy       out  high in BUSY and RESP
module unified_mem_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        MemReq,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        AdrErr,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]  r_cnt;
  logic [31:0] r_adr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_err;

  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_bad;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_accept = (r_state == IDLE) && MemReq;
  assign w_commit = (r_state == BUSY) && (r_cnt == '0);
  assign w_idx    = r_adr[ADDR_WIDTH+1:2];
  // Any address bit above the word index makes the access out of range.
  assign w_bad    = (r_adr[1:0] != '0) || ((r_adr >> (ADDR_WIDTH + 2)) != '0);

  always_ff @(posedge clk) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (MemReq) w_next = BUSY;
      BUSY:    if (r_cnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_commit;
      if (w_accept) begin
        r_cnt   <= 4'(LATENCY);
        r_adr   <= Adr;
        r_wdata <= WriteData;
        r_we    <= MemWrite;
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err <= w_bad;
        if (!w_bad && !r_we) r_rdata <= r_mem[w_idx];
      end
    end
  end

  // Array is never reset; Reset gating drops a write whose commit edge
  // coincides with reset.
  always_ff @(posedge clk) begin
    if (Reset && w_commit && !w_bad && r_we) r_mem[w_idx] <= r_wdata;
  end

  assign ReadData = r_rdata;
  assign MemReady = r_ready;
  assign AdrErr   = r_err;
  assign Busy     = (r_state != IDLE);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
module tb_unified_mem_ctrl;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic        req  [2];
  logic [31:0] adr  [2];
  logic [31:0] wd   [2];
  logic        we   [2];
  logic [31:0] rd   [2];
  logic        rdy  [2];
  logic        err  [2];
  logic        busy [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  vec_t tbl[14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  unified_mem_ctrl #(.ADDR_WIDTH(8), .LATENCY(2)) dut (
    .clk(clk), .Reset(rst[0]), .MemReq(req[0]), .Adr(adr[0]),
    .WriteData(wd[0]), .MemWrite(we[0]), .ReadData(rd[0]),
    .MemReady(rdy[0]), .AdrErr(err[0]), .Busy(busy[0])
  );

  unified_mem_ctrl #(.ADDR_WIDTH(8), .LATENCY(0)) dut0 (
    .clk(clk), .Reset(rst[1]), .MemReq(req[1]), .Adr(adr[1]),
    .WriteData(wd[1]), .MemWrite(we[1]), .ReadData(rd[1]),
    .MemReady(rdy[1]), .AdrErr(err[1]), .Busy(busy[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Response monitor: every MemReady must match the oldest expected result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rdy[d] === 1'b1) begin
        if ((d == 0) ? (sb0.size() == 0) : (sb1.size() == 0)) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ready dut%0d: got MemReady=1 expected 0 (cycle %0d)", d, cyc);
        end else begin
          e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(e.cyc));
          chk("AdrErr", {31'b0, err[d]}, {31'b0, e.err});
          chk("ReadData", rd[d], e.rd);
        end
      end
    end
  end

  task automatic push(input int d, input logic [31:0] erd, input logic eerr);
    exp_t e;
    e.rd  = erd;
    e.err = eerr;
    e.cyc = cyc + lat(d) + 2;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic wait_idle(input int d);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy[d] == 1'b0) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout dut%0d: got Busy=1 expected 0", d);
    end
  endtask

  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] w,
                       input logic wr, input logic [31:0] erd, input logic eerr);
    adr[d] = a;
    wd[d]  = w;
    we[d]  = wr;
    req[d] = 1'b1;
    push(d, erd, eerr);
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    // Scramble the request inputs: the accepted values must already be latched.
    adr[d] = $urandom;
    wd[d]  = $urandom;
    we[d]  = 1'($urandom);
    wait_idle(d);
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0};
    tbl[1]  = '{32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{32'h0000_0000, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{32'h0000_0004, 32'h2222_2222, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[4]  = '{32'h0000_0012, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};
    tbl[5]  = '{32'h0000_0400, 32'hBAD0_BAD0, 1'b1, 32'hDEAD_BEEF, 1'b1};
    tbl[6]  = '{32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111, 1'b0};
    tbl[7]  = '{32'h0000_0020, 32'hCAFE_F00D, 1'b1, 32'h1111_1111, 1'b0};
    tbl[8]  = '{32'h0000_0004, 32'h0,         1'b0, 32'h2222_2222, 1'b0};
    tbl[9]  = '{32'h8000_0010, 32'h0,         1'b0, 32'h2222_2222, 1'b1};
    tbl[10] = '{32'h0000_03FC, 32'h0F0F_0F0F, 1'b1, 32'h2222_2222, 1'b0};
    tbl[11] = '{32'h0000_03FC, 32'h0,         1'b0, 32'h0F0F_0F0F, 1'b0};
    tbl[12] = '{32'h0000_0013, 32'h0,         1'b0, 32'h0F0F_0F0F, 1'b1};
    tbl[13] = '{32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};

    // Reset held with MemReq high: nothing may be accepted.
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req[d] = 1'b1; adr[d] = 32'h10; wd[d] = 32'h5A5A_5A5A; we[d] = 1'b1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("reset_ReadData", rd[d], 32'h0);
        chk("reset_MemReady", {31'b0, rdy[d]}, 32'h0);
        chk("reset_AdrErr", {31'b0, err[d]}, 32'h0);
        chk("reset_Busy", {31'b0, busy[d]}, 32'h0);
      end
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
    end
    @(posedge clk);
    #1;

    // Table-driven writes/reads/error cases, LATENCY=2.
    for (int i = 0; i < 14; i++)
      issue(0, tbl[i].adr, tbl[i].wd, tbl[i].we, tbl[i].erd, tbl[i].eerr);

    // Requests and address changes during BUSY/RESP are ignored.
    adr[0] = 32'h10; we[0] = 1'b0; req[0] = 1'b1;
    push(0, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk);
    #1;
    chk("busy_after_accept", {31'b0, busy[0]}, 32'h1);
    adr[0] = 32'h4; we[0] = 1'b1; wd[0] = 32'h5555_5555;
    repeat (lat(0) + 2) begin
      @(posedge clk);
      #1;
    end
    req[0] = 1'b0; we[0] = 1'b0;
    chk("idle_after_resp", {31'b0, busy[0]}, 32'h0);
    issue(0, 32'h4, 32'h0, 1'b0, 32'h2222_2222, 1'b0);

    // Reset in the first BUSY cycle abandons the write.
    adr[0] = 32'h20; wd[0] = 32'h1234_5678; we[0] = 1'b1; req[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_before_abort", {31'b0, busy[0]}, 32'h1);
    req[0] = 1'b0; rst[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_Busy", {31'b0, busy[0]}, 32'h0);
    chk("abort_MemReady", {31'b0, rdy[0]}, 32'h0);
    chk("abort_ReadData", rd[0], 32'h0);
    rst[0] = 1'b1; we[0] = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    issue(0, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);

    // LATENCY=0 instance: back-to-back at minimum spacing.
    issue(1, 32'h0, 32'hA0A0_A0A0, 1'b1, 32'h0, 1'b0);
    issue(1, 32'h4, 32'hB0B0_B0B0, 1'b1, 32'h0, 1'b0);
    issue(1, 32'h0, 32'h0, 1'b0, 32'hA0A0_A0A0, 1'b0);
    issue(1, 32'h4, 32'h0, 1'b0, 32'hB0B0_B0B0, 1'b0);
    issue(1, 32'h2, 32'h0, 1'b0, 32'hB0B0_B0B0, 1'b1);

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("pending_dut", 32'(sb0.size()), 32'h0);
    chk("pending_dut0", 32'(sb1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
